// File: rtl/rob_multi_commit_pkg.sv
// Shared types and helpers for the multi-commit reorder buffer.
package rob_multi_commit_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_ID_W     = 4;
  localparam int ROB_COMMIT_W = 2;
  localparam int ROB_NUM_CDB  = 2;
  localparam int ROB_XLEN     = 32;
  localparam int ROB_REG_W    = 5;

  typedef enum logic [2:0] {
    ROB_CLS_ALU    = 3'd0,
    ROB_CLS_LOAD   = 3'd1,
    ROB_CLS_STORE  = 3'd2,
    ROB_CLS_BRANCH = 3'd3,
    ROB_CLS_JAL    = 3'd4,
    ROB_CLS_JALR   = 3'd5
  } rob_cls_e;

  function automatic logic is_ctrl(input logic [2:0] c);
    return c == ROB_CLS_BRANCH ||
           c == ROB_CLS_JAL ||
           c == ROB_CLS_JALR;
  endfunction

  function automatic logic is_mem(input logic [2:0] c);
    return c == ROB_CLS_LOAD ||
           c == ROB_CLS_STORE;
  endfunction

  function automatic logic writes_rd(input logic [2:0] c);
    return c == ROB_CLS_ALU ||
           c == ROB_CLS_LOAD ||
           c == ROB_CLS_JAL ||
           c == ROB_CLS_JALR;
  endfunction

endpackage

// File: rtl/rob_multi_commit_cdb_bypass.sv
// Tag match over all writeback buses; the highest-index bus wins.
module rob_cdb_bypass #(
  parameter int NUM_CDB = 2,
  parameter int ID_W    = 4,
  parameter int XLEN    = 32
) (
  input  logic [ID_W-1:0]         tag,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0] cdb_id,
  input  logic [NUM_CDB*XLEN-1:0] cdb_value,
  output logic                    hit,
  output logic [XLEN-1:0]         value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid[i] && cdb_id[i*ID_W +: ID_W] == tag) begin
        hit   = 1'b1;
        value = cdb_value[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocate, CDB capture, up to two
// in-order retirements per cycle with mispredict flush.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int ID_W     = ROB_ID_W,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int NUM_CDB  = ROB_NUM_CDB,
  parameter int XLEN     = ROB_XLEN,
  parameter int REG_W    = ROB_REG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  input  logic [2:0]               alloc_cls,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [XLEN-1:0]          alloc_pred_pc,
  input  logic                     alloc_pred_taken,
  input  logic [REG_W-1:0]         alloc_rd,
  output logic [ID_W-1:0]          alloc_id,
  output logic                     full,
  input  logic [2*ID_W-1:0]        src_tag,
  output logic [2*XLEN-1:0]        src_val,
  output logic [1:0]               src_rdy,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0]  cdb_id,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_next_pc,
  input  logic [NUM_CDB-1:0]       cdb_taken,
  output logic [COMMIT_W-1:0]      cm_valid,
  output logic [COMMIT_W*REG_W-1:0] cm_rd,
  output logic [COMMIT_W*XLEN-1:0] cm_value,
  output logic [COMMIT_W*ID_W-1:0] cm_id,
  output logic                     mem_commit_valid,
  output logic [ID_W-1:0]          mem_commit_id,
  output logic                     pred_upd_valid,
  output logic [XLEN-1:0]          pred_upd_pc,
  output logic                     pred_upd_taken,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc
);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_ready;
  logic [DEPTH-1:0] e_taken;
  logic [2:0]       e_cls  [DEPTH];
  logic [XLEN-1:0]  e_pc   [DEPTH];
  logic [XLEN-1:0]  e_pred [DEPTH];
  logic [XLEN-1:0]  e_val  [DEPTH];
  logic [XLEN-1:0]  e_npc  [DEPTH];
  logic [REG_W-1:0] e_rd   [DEPTH];

  logic [ID_W-1:0] head;
  logic [ID_W-1:0] tail;
  logic [ID_W:0]   count;

  logic [ID_W-1:0] sidx [2];
  logic [1:0]      c;
  logic [1:0]      mis;
  logic [1:0]      n_ret;
  logic            flush;
  logic            accept;

  // Direction is implied by pred_pc; the bit is not needed here.
  logic unused_pred_taken;
  assign unused_pred_taken = alloc_pred_taken;

  assign sidx[0]  = head;
  assign sidx[1]  = head + ID_W'(1);
  assign full     = count == (ID_W+1)'(DEPTH);
  assign alloc_id = tail;

  always_comb begin
    c   = '0;
    mis = '0;
    c[0] = e_valid[head] && e_ready[head];
    mis[0] = c[0] && is_ctrl(e_cls[head]) &&
             (e_npc[head] != e_pred[head]);
    if (COMMIT_W == 2) begin
      c[1] = c[0] && !mis[0] &&
             e_valid[sidx[1]] && e_ready[sidx[1]] &&
             !(is_mem(e_cls[head]) && is_mem(e_cls[sidx[1]])) &&
             !(is_ctrl(e_cls[head]) && is_ctrl(e_cls[sidx[1]]));
    end
    mis[1] = c[1] && is_ctrl(e_cls[sidx[1]]) &&
             (e_npc[sidx[1]] != e_pred[sidx[1]]);
  end

  assign flush  = |mis;
  assign n_ret  = {1'b0, c[0]} + {1'b0, c[1]};
  assign accept = alloc_valid && !full && !flush;

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic            hit;
    logic [XLEN-1:0] bv;
    logic [ID_W-1:0] t;
    assign t = src_tag[s*ID_W +: ID_W];
    rob_cdb_bypass #(
      .NUM_CDB(NUM_CDB),
      .ID_W   (ID_W),
      .XLEN   (XLEN)
    ) u_byp (
      .tag      (t),
      .cdb_valid(cdb_valid),
      .cdb_id   (cdb_id),
      .cdb_value(cdb_value),
      .hit      (hit),
      .value    (bv)
    );
    assign src_rdy[s] = e_ready[t] || hit;
    assign src_val[s*XLEN +: XLEN] = hit ? bv : e_val[t];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      e_valid          <= '0;
      e_ready          <= '0;
      cm_valid         <= '0;
      cm_rd            <= '0;
      cm_value         <= '0;
      cm_id            <= '0;
      mem_commit_valid <= 1'b0;
      mem_commit_id    <= '0;
      pred_upd_valid   <= 1'b0;
      pred_upd_pc      <= '0;
      pred_upd_taken   <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
    end else if (rdy) begin
      cm_valid         <= '0;
      mem_commit_valid <= 1'b0;
      pred_upd_valid   <= 1'b0;
      redirect_valid   <= 1'b0;

      for (int i = 0; i < NUM_CDB; i++) begin
        if (cdb_valid[i] && e_valid[cdb_id[i*ID_W +: ID_W]]) begin
          e_ready[cdb_id[i*ID_W +: ID_W]] <= 1'b1;
          e_val[cdb_id[i*ID_W +: ID_W]]   <= cdb_value[i*XLEN +: XLEN];
          e_npc[cdb_id[i*ID_W +: ID_W]]   <= cdb_next_pc[i*XLEN +: XLEN];
          e_taken[cdb_id[i*ID_W +: ID_W]] <= cdb_taken[i];
        end
      end

      if (accept) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= alloc_cls == ROB_CLS_STORE;
        e_cls[tail]   <= alloc_cls;
        e_pc[tail]    <= alloc_pc;
        e_pred[tail]  <= alloc_pred_pc;
        e_rd[tail]    <= alloc_rd;
        tail          <= tail + ID_W'(1);
      end

      for (int k = 0; k < COMMIT_W; k++) begin
        if (c[k]) begin
          cm_valid[k] <= writes_rd(e_cls[sidx[k]]);
          cm_rd[k*REG_W +: REG_W]   <= e_rd[sidx[k]];
          cm_value[k*XLEN +: XLEN]  <= e_val[sidx[k]];
          cm_id[k*ID_W +: ID_W]     <= sidx[k];
          if (is_mem(e_cls[sidx[k]])) begin
            mem_commit_valid <= 1'b1;
            mem_commit_id    <= sidx[k];
          end
          if (is_ctrl(e_cls[sidx[k]])) begin
            pred_upd_valid <= 1'b1;
            pred_upd_pc    <= e_pc[sidx[k]];
            pred_upd_taken <= e_taken[sidx[k]];
          end
          if (mis[k]) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= e_npc[sidx[k]];
          end
          e_valid[sidx[k]] <= 1'b0;
          e_ready[sidx[k]] <= 1'b0;
        end
      end

      head  <= head + ID_W'(n_ret);
      count <= count + (ID_W+1)'(accept) - (ID_W+1)'(n_ret);

      // Younger entries are on the wrong path; drop everything.
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        e_valid <= '0;
        e_ready <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      for (int i = 0; i < NUM_CDB; i++) begin
        for (int j = i + 1; j < NUM_CDB; j++) begin
          assert (!(cdb_valid[i] && cdb_valid[j] &&
                    cdb_id[i*ID_W +: ID_W] == cdb_id[j*ID_W +: ID_W]));
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: lookup vector table, commit
// scoreboard, and hand sequences for flush/freeze/wrap cases.
module tb_rob_multi_commit;

  localparam logic [2:0] ALU = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] STORE = 3'd2;
  localparam logic [2:0] BRANCH = 3'd3;
  localparam logic [2:0] JALR = 3'd5;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid;
  logic [2:0]  alloc_cls;
  logic [31:0] alloc_pc, alloc_pred_pc;
  logic        alloc_pred_taken;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_id;
  logic        full;
  logic [7:0]  src_tag;
  logic [63:0] src_val;
  logic [1:0]  src_rdy;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_id;
  logic [63:0] cdb_value, cdb_next_pc;
  logic [1:0]  cdb_taken;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_rd;
  logic [63:0] cm_value;
  logic [7:0]  cm_id;
  logic        mem_commit_valid;
  logic [3:0]  mem_commit_id;
  logic        pred_upd_valid;
  logic [31:0] pred_upd_pc;
  logic        pred_upd_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  rob_multi_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_cls(alloc_cls),
    .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc),
    .alloc_pred_taken(alloc_pred_taken), .alloc_rd(alloc_rd),
    .alloc_id(alloc_id), .full(full),
    .src_tag(src_tag), .src_val(src_val), .src_rdy(src_rdy),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id),
    .cdb_value(cdb_value), .cdb_next_pc(cdb_next_pc),
    .cdb_taken(cdb_taken),
    .cm_valid(cm_valid), .cm_rd(cm_rd),
    .cm_value(cm_value), .cm_id(cm_id),
    .mem_commit_valid(mem_commit_valid),
    .mem_commit_id(mem_commit_id),
    .pred_upd_valid(pred_upd_valid), .pred_upd_pc(pred_upd_pc),
    .pred_upd_taken(pred_upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  id;
  } cm_t;

  typedef struct {
    logic [3:0]  t0, t1;
    logic [1:0]  cv;
    logic [3:0]  i0, i1;
    logic [31:0] v0, v1;
    logic [1:0]  er;
    logic [31:0] e0, e1;
    logic [1:0]  m;
  } lk_t;

  cm_t        sb_q[$];
  logic [3:0] mem_q[$];
  lk_t        tbl[6];
  int         checks = 0;
  int         failures = 0;
  logic       rdy_q = 1'b0;
  logic       rst_q = 1'b1;

  always @(posedge clk) begin
    rdy_q <= rdy;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Commit scoreboard: each observed retirement pops one expectation.
  always @(negedge clk) begin
    if (rdy_q && !rst_q) begin
      for (int k = 0; k < 2; k++) begin
        if (cm_valid[k]) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL cm_unexpected slot%0d id=%0d",
                     k, cm_id[k*4 +: 4]);
          end else begin
            cm_t e;
            e = sb_q.pop_front();
            if (cm_rd[k*5 +: 5] !== e.rd ||
                cm_value[k*32 +: 32] !== e.val ||
                cm_id[k*4 +: 4] !== e.id) begin
              failures++;
              $display("FAIL cm_slot%0d got rd=%0d v=%0h id=%0d exp rd=%0d v=%0h id=%0d",
                       k, cm_rd[k*5 +: 5], cm_value[k*32 +: 32],
                       cm_id[k*4 +: 4], e.rd, e.val, e.id);
            end
          end
        end
      end
      if (mem_commit_valid) begin
        checks++;
        if (mem_q.size() == 0) begin
          failures++;
          $display("FAIL mem_unexpected id=%0d", mem_commit_id);
        end else begin
          logic [3:0] m;
          m = mem_q.pop_front();
          if (mem_commit_id !== m) begin
            failures++;
            $display("FAIL mem_id got=%0d exp=%0d", mem_commit_id, m);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_cls = ALU;
    alloc_pc = '0;
    alloc_pred_pc = '0;
    alloc_pred_taken = 1'b0;
    alloc_rd = '0;
    cdb_valid = '0;
    cdb_id = '0;
    cdb_value = '0;
    cdb_next_pc = '0;
    cdb_taken = '0;
  endtask

  task automatic drv_alloc(input logic [2:0] cls, input logic [31:0] pc,
                           input logic [31:0] pred, input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_cls = cls;
    alloc_pc = pc;
    alloc_pred_pc = pred;
    alloc_rd = rd;
  endtask

  task automatic drv_cdb(input int b, input logic [3:0] id,
                         input logic [31:0] val, input logic [31:0] npc,
                         input logic tk);
    cdb_valid[b] = 1'b1;
    cdb_id[b*4 +: 4] = id;
    cdb_value[b*32 +: 32] = val;
    cdb_next_pc[b*32 +: 32] = npc;
    cdb_taken[b] = tk;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] v,
                      input logic [3:0] id);
    cm_t e;
    e.rd = rd;
    e.val = v;
    e.id = id;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd3, 4'd5, 2'b01, 4'd3, 4'd0, 32'h55, 32'h0,
               2'b01, 32'h55, 32'h0, 2'b01};
    tbl[1] = '{4'd4, 4'd3, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0,
               2'b01, 32'hAAAA, 32'h0, 2'b01};
    tbl[2] = '{4'd5, 4'd3, 2'b11, 4'd5, 4'd3, 32'h11, 32'h33,
               2'b11, 32'h11, 32'h33, 2'b11};
    tbl[3] = '{4'd4, 4'd5, 2'b11, 4'd4, 4'd5, 32'h99, 32'h66,
               2'b11, 32'h99, 32'h66, 2'b11};
    tbl[4] = '{4'd3, 4'd4, 2'b00, 4'd3, 4'd4, 32'h55, 32'h77,
               2'b10, 32'h0, 32'hAAAA, 2'b10};
    tbl[5] = '{4'd5, 4'd4, 2'b10, 4'd0, 4'd5, 32'h0, 32'hBB,
               2'b11, 32'hBB, 32'hAAAA, 2'b11};

    rst = 1'b1;
    rdy = 1'b1;
    src_tag = '0;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_alloc_id", 64'(alloc_id), 64'd0);
    chk("rst_cm_valid", 64'(cm_valid), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_mem", 64'(mem_commit_valid), 64'd0);
    chk("rst_src_rdy", 64'(src_rdy), 64'd0);

    // Fill all 16 entries.
    for (int i = 0; i < 16; i++) begin
      drv_alloc(ALU, 32'(i * 4), 32'(i * 4 + 4), 5'(i + 1));
      chk("fill_id", 64'(alloc_id), 64'(i));
      step();
    end
    idle();
    chk("full_after16", 64'(full), 64'd1);
    chk("tail_wrap", 64'(alloc_id), 64'd0);

    drv_alloc(ALU, 32'h999, 32'h99D, 5'd31);
    drv_cdb(0, 4'd0, 32'h1000, 32'h0, 1'b0);
    push(5'd1, 32'h1000, 4'd0);
    step();
    idle();
    chk("alloc17_ignored", 64'(full), 64'd1);
    chk("alloc17_id", 64'(alloc_id), 64'd0);

    drv_cdb(0, 4'd1, 32'h1001, 32'h0, 1'b0);
    push(5'd2, 32'h1001, 4'd1);
    step();
    idle();
    chk("full_after_retire", 64'(full), 64'd0);

    drv_alloc(ALU, 32'h40, 32'h44, 5'd17);
    chk("alloc_at_15_id", 64'(alloc_id), 64'd0);
    step();
    idle();
    chk("alloc_with_retire", 64'(full), 64'd0);

    drv_alloc(ALU, 32'h44, 32'h48, 5'd18);
    chk("alloc_id_1", 64'(alloc_id), 64'd1);
    step();
    idle();
    chk("full_again", 64'(full), 64'd1);

    for (int j = 2; j < 16; j += 2) begin
      drv_cdb(0, 4'(j), 32'h1000 + 32'(j), 32'h0, 1'b0);
      drv_cdb(1, 4'(j + 1), 32'h1001 + 32'(j), 32'h0, 1'b0);
      push(5'(j + 1), 32'h1000 + 32'(j), 4'(j));
      push(5'(j + 2), 32'h1001 + 32'(j), 4'(j + 1));
      step();
      idle();
    end
    drv_cdb(0, 4'd0, 32'h2000, 32'h0, 1'b0);
    drv_cdb(1, 4'd1, 32'h2001, 32'h0, 1'b0);
    push(5'd17, 32'h2000, 4'd0);
    push(5'd18, 32'h2001, 4'd1);
    step();
    idle();
    for (int t = 0; t < 40 && sb_q.size() != 0; t++) step();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    chk("drain_full", 64'(full), 64'd0);
    chk("drain_tail", 64'(alloc_id), 64'd2);

    // Reset while an entry is about to retire.
    drv_alloc(ALU, 32'h300, 32'h304, 5'd7);
    step();
    idle();
    drv_cdb(0, 4'd2, 32'hDEAD, 32'h0, 1'b0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_cm", 64'(cm_valid), 64'd0);
    chk("rst_mid_id", 64'(alloc_id), 64'd0);
    step();
    chk("rst_mid_no_commit", 64'(cm_valid), 64'd0);

    // Dual commit, results arriving out of order.
    drv_alloc(ALU, 32'h10, 32'h14, 5'd3);
    step();
    drv_alloc(ALU, 32'h14, 32'h18, 5'd4);
    step();
    idle();
    drv_cdb(0, 4'd1, 32'h22, 32'h0, 1'b0);
    step();
    idle();
    drv_cdb(1, 4'd0, 32'h7, 32'h0, 1'b0);
    push(5'd3, 32'h7, 4'd0);
    push(5'd4, 32'h22, 4'd1);
    step();
    idle();
    step();
    chk("dual_cm_valid", 64'(cm_valid), 64'd3);
    chk("dual_cm_value", cm_value, {32'h22, 32'h7});
    chk("dual_cm_id", 64'(cm_id), 64'h10);
    step();
    chk("dual_pulse_clear", 64'(cm_valid), 64'd0);
    chk("dual_tail", 64'(alloc_id), 64'd2);

    // Branch mispredict flush.
    drv_alloc(BRANCH, 32'h100, 32'h104, 5'd0);
    step();
    idle();
    drv_alloc(ALU, 32'h104, 32'h108, 5'd9);
    drv_cdb(0, 4'd2, 32'h0, 32'h180, 1'b1);
    step();
    idle();
    drv_alloc(ALU, 32'h500, 32'h504, 5'd10);
    drv_cdb(1, 4'd3, 32'h33, 32'h0, 1'b0);
    step();
    idle();
    chk("mp_redirect", 64'(redirect_valid), 64'd1);
    chk("mp_redirect_pc", 64'(redirect_pc), 64'h180);
    chk("mp_pred_upd", 64'(pred_upd_valid), 64'd1);
    chk("mp_pred_pc", 64'(pred_upd_pc), 64'h100);
    chk("mp_pred_taken", 64'(pred_upd_taken), 64'd1);
    chk("mp_cm_valid", 64'(cm_valid), 64'd0);
    chk("mp_alloc_dropped", 64'(alloc_id), 64'd0);
    step();
    chk("mp_pulse_clear", 64'(redirect_valid), 64'd0);
    step();
    step();
    chk("mp_flushed", 64'(cm_valid), 64'd0);

    // JALR correctly predicted.
    drv_alloc(JALR, 32'h1F0, 32'h200, 5'd1);
    step();
    idle();
    drv_cdb(0, 4'd0, 32'h1F4, 32'h200, 1'b1);
    push(5'd1, 32'h1F4, 4'd0);
    step();
    idle();
    step();
    chk("jalr_pred_upd", 64'(pred_upd_valid), 64'd1);
    chk("jalr_pred_pc", 64'(pred_upd_pc), 64'h1F0);
    chk("jalr_no_redirect", 64'(redirect_valid), 64'd0);
    chk("jalr_cm_valid", 64'(cm_valid), 64'd1);

    // Load then store: one memory retirement per cycle.
    drv_alloc(LOAD, 32'h20, 32'h24, 5'd5);
    step();
    idle();
    drv_alloc(STORE, 32'h24, 32'h28, 5'd0);
    drv_cdb(0, 4'd1, 32'h77, 32'h0, 1'b0);
    push(5'd5, 32'h77, 4'd1);
    mem_q.push_back(4'd1);
    mem_q.push_back(4'd2);
    step();
    idle();
    step();
    chk("ld_mem_valid", 64'(mem_commit_valid), 64'd1);
    chk("ld_mem_id", 64'(mem_commit_id), 64'd1);
    chk("ld_cm_valid", 64'(cm_valid), 64'd1);
    step();
    chk("st_mem_valid", 64'(mem_commit_valid), 64'd1);
    chk("st_mem_id", 64'(mem_commit_id), 64'd2);
    chk("st_cm_valid", 64'(cm_valid), 64'd0);
    step();
    chk("mem_pulse_clear", 64'(mem_commit_valid), 64'd0);

    // Lookup table, with state frozen by rdy=0.
    drv_alloc(ALU, 32'h30, 32'h34, 5'd10);
    step();
    drv_alloc(ALU, 32'h34, 32'h38, 5'd11);
    step();
    drv_alloc(ALU, 32'h38, 32'h3C, 5'd12);
    step();
    idle();
    drv_cdb(0, 4'd4, 32'hAAAA, 32'h0, 1'b0);
    step();
    idle();
    rdy = 1'b0;
    for (int v = 0; v < 6; v++) begin
      src_tag = {tbl[v].t1, tbl[v].t0};
      cdb_valid = tbl[v].cv;
      cdb_id = {tbl[v].i1, tbl[v].i0};
      cdb_value = {tbl[v].v1, tbl[v].v0};
      #1;
      chk($sformatf("lk%0d_rdy", v), 64'(src_rdy), 64'(tbl[v].er));
      if (tbl[v].m[0])
        chk($sformatf("lk%0d_val0", v), 64'(src_val[31:0]), 64'(tbl[v].e0));
      if (tbl[v].m[1])
        chk($sformatf("lk%0d_val1", v), 64'(src_val[63:32]), 64'(tbl[v].e1));
    end
    rdy = 1'b1;
    idle();
    drv_cdb(0, 4'd3, 32'h55, 32'h0, 1'b0);
    push(5'd10, 32'h55, 4'd3);
    push(5'd11, 32'hAAAA, 4'd4);
    step();
    idle();
    step();
    chk("frz_pre_cm", 64'(cm_valid), 64'd3);
    rdy = 1'b0;
    drv_alloc(ALU, 32'h60, 32'h64, 5'd20);
    drv_cdb(0, 4'd5, 32'h123, 32'h0, 1'b0);
    step();
    step();
    step();
    chk("frz_hold_cm", 64'(cm_valid), 64'd3);
    chk("frz_tail", 64'(alloc_id), 64'd6);
    idle();
    src_tag = {4'd0, 4'd5};
    #1;
    chk("frz_no_capture", 64'(src_rdy[0]), 64'd0);
    rdy = 1'b1;
    step();
    chk("frz_release_cm", 64'(cm_valid), 64'd0);
    chk("frz_release_tail", 64'(alloc_id), 64'd6);
    step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
